// File: rtl/fpu_resp_buffer_if.sv
// rtl/fpu_resp_buffer_if.sv - handshake bundle between interconnect, FPU wrapper and response buffer
interface fpu_resp_buffer_if #(
  parameter int ID_WIDTH        = 9,
  parameter int DATA_WIDTH      = 32,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int DEPTH           = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Interconnect request side
  logic                       req_i;
  logic                       gnt_o;

  // FPU wrapper request side
  logic                       fpu_req_o;
  logic                       fpu_gnt_i;

  // FPU wrapper result side (cannot be back-pressured)
  logic                       fpu_rvalid_i;
  logic [DATA_WIDTH-1:0]      fpu_rdata_i;
  logic [FLAGS_OUT_WIDTH-1:0] fpu_rflags_i;
  logic [ID_WIDTH-1:0]        fpu_rID_i;

  // Buffered response toward the interconnect
  logic                       rvalid_o;
  logic                       rready_i;
  logic [DATA_WIDTH-1:0]      rdata_o;
  logic [FLAGS_OUT_WIDTH-1:0] rflags_o;
  logic [ID_WIDTH-1:0]        rID_o;

  // Status
  logic [CNT_W-1:0]           outstanding_o;
  logic                       overflow_o;

  modport slave (
    input  req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rID_i, rready_i,
    output gnt_o, fpu_req_o, rvalid_o, rdata_o, rflags_o, rID_o, outstanding_o, overflow_o
  );

  modport master (
    output req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i, fpu_rID_i, rready_i,
    input  gnt_o, fpu_req_o, rvalid_o, rdata_o, rflags_o, rID_o, outstanding_o, overflow_o
  );
endinterface

// File: rtl/fpu_resp_buffer.sv
// rtl/fpu_resp_buffer.sv - credit-throttled FIFO holding FPU results until the interconnect accepts them
module fpu_resp_buffer #(
  parameter int ID_WIDTH        = 9,
  parameter int DATA_WIDTH      = 32,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int DEPTH           = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fpu_resp_buffer_if.slave  bus
);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = DATA_WIDTH + FLAGS_OUT_WIDTH + ID_WIDTH;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [CNT_W-1:0]   credits;
  logic [CNT_W-1:0]   fill;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               overflow_q;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic avail;
  logic issue;
  logic pop;
  logic full;
  logic push;
  logic drop;

  // Pointers wrap by compare so DEPTH need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  // Credit gate looks only at the registered count, so a freed credit is usable next cycle
  assign avail = (credits < DEPTH_C);
  assign issue = bus.req_i & bus.fpu_gnt_i & avail;
  assign pop   = (fill != '0) & bus.rready_i;
  assign full  = (fill == DEPTH_C);
  // A pop in the same cycle frees the slot the incoming result lands in
  assign push  = bus.fpu_rvalid_i & (~full | pop);
  assign drop  = bus.fpu_rvalid_i & full & ~pop;

  assign bus.fpu_req_o     = bus.req_i & avail;
  assign bus.gnt_o         = bus.fpu_gnt_i & avail;
  assign bus.rvalid_o      = (fill != '0);
  assign {bus.rdata_o, bus.rflags_o, bus.rID_o} = mem[rd_ptr];
  assign bus.outstanding_o = credits;
  assign bus.overflow_o    = overflow_q;

  // Credit counter: +1 per issued op, -1 per accepted response; floors at zero after a mid-flight reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= '0;
    end else if (issue && !pop) begin
      credits <= credits + CNT_ONE;
    end else if (pop && !issue && credits != '0) begin
      credits <= credits - CNT_ONE;
    end
  end

  // FIFO bookkeeping: pointers and fill level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) begin
        fill <= fill + CNT_ONE;
      end else if (pop && !push) begin
        fill <= fill - CNT_ONE;
      end
    end
  end

  // Result storage; contents are meaningless until covered by fill, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.fpu_rdata_i, bus.fpu_rflags_i, bus.fpu_rID_i};
    end
  end

  // Sticky flag for a result that arrived with nowhere to go
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fpu_resp_buffer.sv
// tb/tb_fpu_resp_buffer.sv - self-checking bench for fpu_resp_buffer
module tb_fpu_resp_buffer;
  localparam int IDW   = 9;
  localparam int DW    = 32;
  localparam int FW    = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_resp_buffer_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .FLAGS_OUT_WIDTH(FW), .DEPTH(DEPTH)) bus ();

  fpu_resp_buffer #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .FLAGS_OUT_WIDTH(FW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [FW-1:0]  flags;
    logic [IDW-1:0] id;
  } resp_t;

  typedef struct {
    logic           req, fgnt, rv, rr;
    logic [IDW-1:0] id;
    logic           e_freq, e_gnt, e_rvalid;
    int             e_out;
    logic [IDW-1:0] e_id;
  } vec_t;

  resp_t          mq[$];
  int             m_credits;
  bit             m_ovf;
  int             checks = 0;
  int             errors = 0;

  logic           cur_req, cur_fgnt, cur_rv, cur_rr;
  logic [IDW-1:0] cur_id;
  logic [DW-1:0]  cur_data;
  logic [FW-1:0]  cur_flags;

  vec_t tbl[14];

  function automatic logic [DW-1:0] mkd(input logic [IDW-1:0] id);
    return {id[7:0], 8'h5A, ~id[7:0], 8'hC3};
  endfunction

  function automatic vec_t mkv(input logic req, fgnt, rv, rr, input logic [IDW-1:0] id,
                               input logic efr, eg, erv, input int eout, input logic [IDW-1:0] eid);
    vec_t v;
    v.req = req; v.fgnt = fgnt; v.rv = rv; v.rr = rr; v.id = id;
    v.e_freq = efr; v.e_gnt = eg; v.e_rvalid = erv; v.e_out = eout; v.e_id = eid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, fgnt, rv, rr, input logic [IDW-1:0] id, input logic [DW-1:0] data);
    cur_req = req; cur_fgnt = fgnt; cur_rv = rv; cur_rr = rr;
    cur_id = id; cur_data = data; cur_flags = id[4:0] ^ 5'h0A;
    bus.req_i        = cur_req;
    bus.fpu_gnt_i    = cur_fgnt;
    bus.fpu_rvalid_i = cur_rv;
    bus.rready_i     = cur_rr;
    bus.fpu_rID_i    = cur_id;
    bus.fpu_rdata_i  = cur_data;
    bus.fpu_rflags_i = cur_flags;
  endtask

  task automatic model_check();
    logic av;
    av = (m_credits < DEPTH);
    chk("fpu_req_o", bus.fpu_req_o, cur_req & av);
    chk("gnt_o", bus.gnt_o, cur_fgnt & av);
    chk("outstanding_o", bus.outstanding_o, m_credits);
    chk("overflow_o", bus.overflow_o, m_ovf);
    chk("rvalid_o", bus.rvalid_o, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("rdata_o", bus.rdata_o, mq[0].data);
      chk("rflags_o", bus.rflags_o, mq[0].flags);
      chk("rID_o", bus.rID_o, mq[0].id);
    end
  endtask

  task automatic cyc(input logic req, fgnt, rv, rr, input logic [IDW-1:0] id, input logic [DW-1:0] data);
    drive(req, fgnt, rv, rr, id, data);
    #1;
    model_check();
  endtask

  task automatic advance();
    bit av, iss, pp;
    av  = (m_credits < DEPTH);
    iss = cur_req && cur_fgnt && av;
    pp  = (mq.size() != 0) && cur_rr;
    if (iss && !pp) m_credits++;
    else if (pp && !iss && m_credits > 0) m_credits--;
    if (pp) void'(mq.pop_front());
    if (cur_rv) begin
      if (mq.size() < DEPTH) mq.push_back('{data: cur_data, flags: cur_flags, id: cur_id});
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic req, fgnt, rv, rr, input logic [IDW-1:0] id);
    cyc(req, fgnt, rv, rr, id, mkd(id));
    advance();
  endtask

  task automatic model_reset();
    mq.delete();
    m_credits = 0;
    m_ovf = 1'b0;
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, '0, '0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic fill_four();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, '0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 0, IDW'(i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Credit-limit walk from reset: inputs and the outputs expected in the same cycle
    tbl[0]  = mkv(1, 1, 0, 0, 9'd0, 1, 1, 0, 0, 9'd0);
    tbl[1]  = mkv(1, 1, 0, 0, 9'd0, 1, 1, 0, 1, 9'd0);
    tbl[2]  = mkv(1, 1, 0, 0, 9'd0, 1, 1, 0, 2, 9'd0);
    tbl[3]  = mkv(1, 1, 0, 0, 9'd0, 1, 1, 0, 3, 9'd0);
    tbl[4]  = mkv(1, 1, 0, 0, 9'd0, 0, 0, 0, 4, 9'd0);
    tbl[5]  = mkv(0, 0, 1, 0, 9'd1, 0, 0, 0, 4, 9'd0);
    tbl[6]  = mkv(1, 1, 1, 0, 9'd2, 0, 0, 1, 4, 9'd1);
    tbl[7]  = mkv(1, 1, 0, 1, 9'd0, 0, 0, 1, 4, 9'd1);
    tbl[8]  = mkv(1, 1, 0, 0, 9'd0, 1, 1, 1, 3, 9'd2);
    tbl[9]  = mkv(0, 0, 0, 1, 9'd0, 0, 0, 1, 4, 9'd2);
    tbl[10] = mkv(1, 1, 0, 1, 9'd0, 1, 1, 0, 3, 9'd0);
    tbl[11] = mkv(0, 0, 1, 0, 9'd3, 0, 0, 0, 4, 9'd0);
    tbl[12] = mkv(1, 1, 0, 1, 9'd0, 0, 0, 1, 4, 9'd3);
    tbl[13] = mkv(0, 0, 0, 0, 9'd0, 0, 0, 0, 3, 9'd0);

    model_reset();
    drive(0, 0, 0, 0, '0, '0);

    // Single operation with a two-cycle FPU latency
    apply_reset();
    cyc(1, 1, 0, 0, '0, '0);
    chk("t2_gnt", bus.gnt_o, 1'b1);
    chk("t2_out0", bus.outstanding_o, 0);
    advance();
    cyc(0, 0, 0, 0, '0, '0);
    chk("t2_out1", bus.outstanding_o, 1);
    advance();
    cyc(0, 0, 1, 0, 9'd5, 32'h3F800000);
    chk("t2_no_bypass", bus.rvalid_o, 1'b0);
    advance();
    cyc(0, 0, 0, 1, '0, '0);
    chk("t2_rvalid", bus.rvalid_o, 1'b1);
    chk("t2_rdata", bus.rdata_o, 32'h3F800000);
    chk("t2_rid", bus.rID_o, 5);
    chk("t2_out_before_pop", bus.outstanding_o, 1);
    advance();
    cyc(0, 0, 0, 0, '0, '0);
    chk("t2_rvalid_after", bus.rvalid_o, 1'b0);
    chk("t2_out_after", bus.outstanding_o, 0);
    advance();

    // Table-driven credit limit and next-cycle credit reuse
    apply_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].req, tbl[i].fgnt, tbl[i].rv, tbl[i].rr, tbl[i].id, mkd(tbl[i].id));
      chk($sformatf("tbl%0d_fpu_req", i), bus.fpu_req_o, tbl[i].e_freq);
      chk($sformatf("tbl%0d_gnt", i), bus.gnt_o, tbl[i].e_gnt);
      chk($sformatf("tbl%0d_rvalid", i), bus.rvalid_o, tbl[i].e_rvalid);
      chk($sformatf("tbl%0d_out", i), bus.outstanding_o, tbl[i].e_out);
      if (tbl[i].e_rvalid) chk($sformatf("tbl%0d_rid", i), bus.rID_o, tbl[i].e_id);
      advance();
    end

    // Back-pressure: four stored results held stable, then drained in order
    apply_reset();
    fill_four();
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, '0, '0);
      chk("t4_stall_rid", bus.rID_o, 1);
      chk("t4_stall_rdata", bus.rdata_o, mkd(9'd1));
      chk("t4_stall_rvalid", bus.rvalid_o, 1'b1);
      advance();
    end
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 1, '0, '0);
      chk("t4_drain_rid", bus.rID_o, k);
      advance();
    end
    cyc(0, 0, 0, 0, '0, '0);
    chk("t4_empty", bus.rvalid_o, 1'b0);
    advance();

    // Push and pop together while full, then issue and pop together
    apply_reset();
    fill_four();
    cyc(0, 0, 1, 1, 9'd9, mkd(9'd9));
    advance();
    cyc(0, 0, 0, 0, '0, '0);
    chk("t5_no_ovf", bus.overflow_o, 1'b0);
    chk("t5_head", bus.rID_o, 2);
    chk("t5_out", bus.outstanding_o, 3);
    advance();
    cyc(1, 1, 0, 1, '0, '0);
    advance();
    cyc(0, 0, 0, 0, '0, '0);
    chk("t5_issue_pop_out", bus.outstanding_o, 3);
    chk("t5_head2", bus.rID_o, 3);
    advance();
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 1, '0);
    cyc(0, 0, 0, 1, '0, '0);
    chk("t5_last_rid", bus.rID_o, 9);
    advance();
    cyc(0, 0, 0, 0, '0, '0);
    chk("t5_empty", bus.rvalid_o, 1'b0);
    advance();

    // Protocol violation: push into full FIFO with no pop
    apply_reset();
    fill_four();
    cyc(0, 0, 1, 0, 9'd13, mkd(9'd13));
    chk("t6_ovf_before", bus.overflow_o, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, '0, '0);
      chk("t6_ovf_sticky", bus.overflow_o, 1'b1);
      chk("t6_head_kept", bus.rID_o, 1);
      advance();
    end
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 1, '0, '0);
      chk("t6_drain_rid", bus.rID_o, k);
      chk("t6_ovf_drain", bus.overflow_o, 1'b1);
      advance();
    end
    cyc(0, 0, 0, 0, '0, '0);
    chk("t6_dropped", bus.rvalid_o, 1'b0);
    advance();

    // Mid-traffic reset with stored data, credits in use and overflow set
    step(1, 1, 0, 0, '0);
    step(1, 1, 1, 0, 9'd21);
    drive(0, 0, 0, 0, '0, '0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("t1_rvalid", bus.rvalid_o, 1'b0);
    chk("t1_out", bus.outstanding_o, 0);
    chk("t1_ovf", bus.overflow_o, 1'b0);
    chk("t1_gnt", bus.gnt_o, 1'b0);
    model_check();
    rst_n = 1'b1;
    advance();

    // Random traffic against the queue model; results only return for ops in flight
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      logic rq, fg, rv, rr;
      int inflight;
      inflight = m_credits - mq.size();
      rq = 1'($urandom_range(0, 1));
      fg = 1'($urandom_range(0, 3) != 0);
      rv = (inflight > 0) && ($urandom_range(0, 2) != 0);
      rr = (n < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cyc(rq, fg, rv, rr, IDW'($urandom), $urandom);
      advance();
    end
    cyc(0, 0, 0, 0, '0, '0);
    chk("rand_no_ovf", bus.overflow_o, 1'b0);
    advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
